yuv_encoder_m1: RTL and testbench

Colour-space encoder, the write-side counterpart of the Milestone 1 decoder. It reads packed 8-bit RGB pixels from SRAM, converts each pixel to BT.601 Y and each horizontal pixel pair to U/V, and writes Y, U and V into the YUV memory map that the decoder consumes. It owns the SRAM bus between `M1E_start` and `M1E_done`, and the top-level arbiter muxes it onto the SRAM controller.

---
 rtl/yuv_encoder_pkg.sv | 48 ++++
 rtl/yuv_encoder_m1_core.sv | 35 +++
 rtl/yuv_encoder_m1.sv | 115 +++++++++++
 tb/tb_yuv_encoder_m1.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/yuv_encoder_pkg.sv
// yuv_encoder_pkg: shared states, memory map and BT.601 coefficients for the M1 encoder
package yuv_encoder_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_G0, S_G1, S_G2, S_G3, S_G4, S_G5,
    S_G6, S_G7, S_G8, S_G9, S_G10, S_G11, S_DONE
  } M1E_state_type;

  localparam logic [17:0] DEF_RGB_BASE = 18'd146944;
  localparam logic [17:0] DEF_Y_BASE = 18'd0;
  localparam logic [17:0] DEF_U_BASE = 18'd38400;
  localparam logic [17:0] DEF_V_BASE = 18'd57600;
  localparam int DEF_NUM_GROUPS = 19200;

  localparam logic signed [17:0] C_YR = 18'sd16843;
  localparam logic signed [17:0] C_YG = 18'sd33030;
  localparam logic signed [17:0] C_YB = 18'sd6423;
  localparam logic signed [17:0] C_UR = -18'sd9699;
  localparam logic signed [17:0] C_UG = -18'sd19071;
  localparam logic signed [17:0] C_UB = 18'sd28770;
  localparam logic signed [17:0] C_VR = 18'sd28770;
  localparam logic signed [17:0] C_VG = -18'sd24117;
  localparam logic signed [17:0] C_VB = -18'sd4653;

  function automatic logic signed [31:0] sx(logic signed [17:0] c);
    return {{14{c[17]}}, c};
  endfunction

  function automatic logic signed [31:0] ext(logic [7:0] x);
    return {24'd0, x};
  endfunction

  // one 16.16 fixed-point dot product, rounded, offset and clipped to a byte
  function automatic logic [7:0] conv(logic signed [17:0] cr, logic signed [17:0] cg,
                                      logic signed [17:0] cb, logic [7:0] r, logic [7:0] g,
                                      logic [7:0] b, logic signed [31:0] off);
    logic signed [31:0] s;
    s = ((sx(cr) * ext(r) + sx(cg) * ext(g) + sx(cb) * ext(b) + 32'sd32768) >>> 16) + off;
    return s < 0 ? 8'd0 : (s > 255 ? 8'd255 : s[7:0]);
  endfunction

  function automatic logic [7:0] avg(logic [7:0] a, logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b} + 9'd1;
    return s[8:1];
  endfunction

endpackage

// File: rtl/yuv_encoder_m1_core.sv
// rgb_to_yuv_core: registered RGB to YUV conversion, chroma taken from a separate (averaged) input
module rgb_to_yuv_core
  import yuv_encoder_pkg::*;
(
  input  logic       CLOCK_50_I,
  input  logic       resetn,
  input  logic       en,
  input  logic       mode,
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  input  logic [7:0] r_c,
  input  logic [7:0] g_c,
  input  logic [7:0] b_c,
  output logic [7:0] y,
  output logic [7:0] u,
  output logic [7:0] v
);

  // results load only when enabled so they stay stable while the writes use them
  always_ff @(posedge CLOCK_50_I) begin
    if (!resetn) begin
      y <= '0;
      u <= '0;
      v <= '0;
    end else if (en) begin
      y <= conv(C_YR, C_YG, C_YB, r, g, b, 32'sd16);
      if (mode) begin
        u <= conv(C_UR, C_UG, C_UB, r_c, g_c, b_c, 32'sd128);
        v <= conv(C_VR, C_VG, C_VB, r_c, g_c, b_c, 32'sd128);
      end
    end
  end

endmodule

// File: rtl/yuv_encoder_m1.sv
// yuv_encoder_m1: reads packed RGB from SRAM, writes BT.601 Y and 2:1 decimated U/V
module yuv_encoder_m1
  import yuv_encoder_pkg::*;
#(
  parameter logic [17:0] RGB_BASE = DEF_RGB_BASE,
  parameter logic [17:0] Y_BASE = DEF_Y_BASE,
  parameter logic [17:0] U_BASE = DEF_U_BASE,
  parameter logic [17:0] V_BASE = DEF_V_BASE,
  parameter int NUM_GROUPS = DEF_NUM_GROUPS
) (
  input  logic        CLOCK_50_I,
  input  logic        Resetn,
  input  logic        M1E_start,
  output logic        M1E_done,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data
);

  M1E_state_type state, state_n;
  logic [17:0] rgb_addr, y_addr, u_addr, v_addr;
  logic [14:0] grp;
  logic [15:0] wbuf [6];
  logic [2:0] widx, p;
  logic last;
  logic [7:0] ya, ua, va, yb, ub, vb;

  assign last = grp == 15'(NUM_GROUPS - 1);
  assign widx = 3'(state - S_G2);
  // G5 converts pixels 0/1 (words 0..2), G8 converts pixels 2/3 (words 3..5)
  assign p = state == S_G8 ? 3'd3 : 3'd0;

  rgb_to_yuv_core u_even (
    .CLOCK_50_I(CLOCK_50_I), .resetn(Resetn),
    .en(state == S_G5 || state == S_G8), .mode(state == S_G8),
    .r(wbuf[p][15:8]), .g(wbuf[p][7:0]), .b(wbuf[p + 3'd1][15:8]),
    .r_c(avg(wbuf[0][15:8], wbuf[1][7:0])),
    .g_c(avg(wbuf[0][7:0], wbuf[2][15:8])),
    .b_c(avg(wbuf[1][15:8], wbuf[2][7:0])),
    .y(ya), .u(ua), .v(va)
  );

  rgb_to_yuv_core u_odd (
    .CLOCK_50_I(CLOCK_50_I), .resetn(Resetn),
    .en(state == S_G5 || state == S_G8), .mode(state == S_G8),
    .r(wbuf[p + 3'd1][7:0]), .g(wbuf[p + 3'd2][15:8]), .b(wbuf[p + 3'd2][7:0]),
    .r_c(avg(wbuf[3][15:8], wbuf[4][7:0])),
    .g_c(avg(wbuf[3][7:0], wbuf[5][15:8])),
    .b_c(avg(wbuf[4][15:8], wbuf[5][7:0])),
    .y(yb), .u(ub), .v(vb)
  );

  // state register, address counters, group counter and read capture buffer
  always_ff @(posedge CLOCK_50_I) begin
    if (!Resetn) begin
      state <= S_IDLE;
      rgb_addr <= RGB_BASE;
      y_addr <= Y_BASE;
      u_addr <= U_BASE;
      v_addr <= V_BASE;
      grp <= '0;
      wbuf <= '{default: 16'd0};
    end else begin
      state <= state_n;
      if (state == S_IDLE && M1E_start) begin
        rgb_addr <= RGB_BASE;
        y_addr <= Y_BASE;
        u_addr <= U_BASE;
        v_addr <= V_BASE;
        grp <= '0;
      end
      if (state >= S_G0 && state <= S_G5) rgb_addr <= rgb_addr + 18'd1;
      if (state >= S_G2 && state <= S_G7) wbuf[widx] <= SRAM_read_data;
      if (state == S_G8 || state == S_G9) y_addr <= y_addr + 18'd1;
      if (state == S_G10) u_addr <= u_addr + 18'd1;
      if (state == S_G11) v_addr <= v_addr + 18'd1;
      if (state == S_G11 && !last) grp <= grp + 15'd1;
    end
  end

  // next state and SRAM bus drive; G states advance in sequence by default
  always_comb begin
    state_n = M1E_state_type'(state + 4'd1);
    SRAM_address = rgb_addr;
    SRAM_write_data = '0;
    SRAM_we_n = 1'b1;
    M1E_done = 1'b0;
    case (state)
      S_IDLE: state_n = M1E_start ? S_G0 : S_IDLE;
      S_G8, S_G9: begin
        SRAM_we_n = 1'b0;
        SRAM_address = y_addr;
        SRAM_write_data = {ya, yb};
      end
      S_G10: begin
        SRAM_we_n = 1'b0;
        SRAM_address = u_addr;
        SRAM_write_data = {ua, ub};
      end
      S_G11: begin
        SRAM_we_n = 1'b0;
        SRAM_address = v_addr;
        SRAM_write_data = {va, vb};
        state_n = last ? S_DONE : S_G0;
      end
      S_DONE: begin
        M1E_done = 1'b1;
        state_n = S_IDLE;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_yuv_encoder_m1.sv
// tb_yuv_encoder_m1: directed frames checked against a formula-level model of the YUV write stream
module tb_yuv_encoder_m1;
  import yuv_encoder_pkg::*;

  localparam int NG = 128;
  localparam int NW = 6 * NG;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0;
  logic done, we_n;
  logic [17:0] addr;
  logic [15:0] wdata, rdata;
  logic [15:0] img [NW];
  logic [15:0] wr [int];
  logic [17:0] a1, a2;
  int n_chk = 0;
  int n_fail = 0;
  logic act = 1'b0;
  int t = 0;

  always #5 clk = ~clk;

  yuv_encoder_m1 #(.NUM_GROUPS(NG)) dut (
    .CLOCK_50_I(clk), .Resetn(resetn), .M1E_start(start), .M1E_done(done),
    .SRAM_address(addr), .SRAM_write_data(wdata), .SRAM_we_n(we_n), .SRAM_read_data(rdata)
  );

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int clip(int x);
    return x < 0 ? 0 : (x > 255 ? 255 : x);
  endfunction

  function automatic logic [7:0] yf(int r, int g, int b);
    return 8'(clip(((16843 * r + 33030 * g + 6423 * b + 32768) >>> 16) + 16));
  endfunction

  function automatic logic [7:0] uf(int r, int g, int b);
    return 8'(clip(((-9699 * r - 19071 * g + 28770 * b + 32768) >>> 16) + 128));
  endfunction

  function automatic logic [7:0] vf(int r, int g, int b);
    return 8'(clip(((28770 * r - 24117 * g - 4653 * b + 32768) >>> 16) + 128));
  endfunction

  // channel c (0=R,1=G,2=B) of frame pixel q, from the 3-words-per-2-pixels packing
  function automatic int ch(int q, int c);
    int w;
    w = 3 * (q / 2);
    if (q % 2 == 0) return c == 0 ? int'(img[w][15:8]) : (c == 1 ? int'(img[w][7:0]) : int'(img[w+1][15:8]));
    return c == 0 ? int'(img[w+1][7:0]) : (c == 1 ? int'(img[w+2][15:8]) : int'(img[w+2][7:0]));
  endfunction

  function automatic int av(int q, int c);
    return (ch(q, c) + ch(q + 1, c) + 1) >> 1;
  endfunction

  function automatic logic [7:0] yq(int q);
    return yf(ch(q, 0), ch(q, 1), ch(q, 2));
  endfunction

  function automatic logic [7:0] uq(int q);
    return uf(av(q, 0), av(q, 1), av(q, 2));
  endfunction

  function automatic logic [7:0] vq(int q);
    return vf(av(q, 0), av(q, 1), av(q, 2));
  endfunction

  // SRAM read model: data appears two cycles after its address
  always @(posedge clk) begin
    a1 <= addr;
    a2 <= a1;
  end

  always_comb begin
    int idx;
    idx = int'(a2) - int'(DEF_RGB_BASE);
    rdata = (idx >= 0 && idx < NW) ? img[idx] : 16'h0000;
  end

  // frame timeline: t is the cycle number since start was accepted (1 = first group cycle)
  always @(posedge clk) begin
    if (!resetn) begin
      act <= 1'b0;
      t <= 0;
    end else if (act) begin
      if (t == 12 * NG + 1) act <= 1'b0;
      else t <= t + 1;
    end else if (start) begin
      act <= 1'b1;
      t <= 1;
    end
  end

  // compare DUT bus against the timeline every cycle
  always @(negedge clk) begin
    int ph, g;
    logic [17:0] ea;
    logic [15:0] ed;
    if (resetn) begin
      if (!act) begin
        chk("idle_we_n", 32'(we_n), 32'd1);
        chk("idle_done", 32'(done), 32'd0);
      end else if (t == 12 * NG + 1) begin
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_we_n", 32'(we_n), 32'd1);
      end else begin
        ph = (t - 1) % 12;
        g = (t - 1) / 12;
        chk("busy_done", 32'(done), 32'd0);
        if (ph >= 8) begin
          ea = ph == 8 ? DEF_Y_BASE + 18'(2 * g) : ph == 9 ? DEF_Y_BASE + 18'(2 * g + 1) :
               ph == 10 ? DEF_U_BASE + 18'(g) : DEF_V_BASE + 18'(g);
          ed = ph == 8 ? {yq(4 * g), yq(4 * g + 1)} : ph == 9 ? {yq(4 * g + 2), yq(4 * g + 3)} :
               ph == 10 ? {uq(4 * g), uq(4 * g + 2)} : {vq(4 * g), vq(4 * g + 2)};
          chk("wr_we_n", 32'(we_n), 32'd0);
          chk("wr_addr", 32'(addr), 32'(ea));
          chk("wr_data", 32'(wdata), 32'(ed));
          if (!we_n) wr[int'(addr)] = wdata;
        end else begin
          chk("rd_we_n", 32'(we_n), 32'd1);
          if (ph < 6) chk("rd_addr", 32'(addr), 32'(DEF_RGB_BASE) + 32'(6 * g + ph));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_frame(int poke);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12 * NG + 20 && act; i++) begin
      start = (poke != 0 && t == poke) ? 1'b1 : 1'b0;
      tick();
    end
    start = 1'b0;
    chk("frame_end", 32'(act), 32'd0);
    tick();
  endtask

  task automatic fill3(logic [15:0] w0, logic [15:0] w1, logic [15:0] w2);
    for (int i = 0; i < NW; i += 3) begin
      img[i] = w0;
      img[i+1] = w1;
      img[i+2] = w2;
    end
  endtask

  initial begin
    fill3(16'h0000, 16'h0000, 16'h0000);
    tick();
    tick();
    chk("rst_addr", 32'(addr), 32'(DEF_RGB_BASE));
    chk("rst_wdata", 32'(wdata), 32'd0);
    chk("rst_we_n", 32'(we_n), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    resetn = 1'b1;
    tick();

    chk("pin_y_red", 32'(yf(255, 0, 0)), 32'd82);
    chk("pin_u_red", 32'(uf(255, 0, 0)), 32'd90);
    chk("pin_v_red", 32'(vf(255, 0, 0)), 32'd240);
    chk("pin_y_blue", 32'(yf(0, 0, 255)), 32'd41);
    chk("pin_u_avg", 32'(uf(128, 0, 128)), 32'h0A5);
    chk("pin_v_avg", 32'(vf(128, 0, 128)), 32'h0AF);
    chk("pin_y_white", 32'(yf(255, 255, 255)), 32'd235);

    run_frame(0);
    chk("black_y0", 32'(wr[0]), 32'h1010);
    chk("black_ylast", 32'(wr[2 * NG - 1]), 32'h1010);
    chk("black_u0", 32'(wr[int'(DEF_U_BASE)]), 32'h8080);
    chk("black_vlast", 32'(wr[int'(DEF_V_BASE) + NG - 1]), 32'h8080);

    fill3(16'hFFFF, 16'hFFFF, 16'hFFFF);
    run_frame(0);
    chk("white_y0", 32'(wr[0]), 32'hEBEB);
    chk("white_u0", 32'(wr[int'(DEF_U_BASE)]), 32'h8080);
    chk("white_v0", 32'(wr[int'(DEF_V_BASE)]), 32'h8080);

    fill3(16'hFF00, 16'h00FF, 16'h0000);
    run_frame(0);
    chk("red_y0", 32'(wr[0]), 32'h5252);
    chk("red_y1", 32'(wr[1]), 32'h5252);
    chk("red_u0", 32'(wr[int'(DEF_U_BASE)]), 32'h5A5A);
    chk("red_v0", 32'(wr[int'(DEF_V_BASE)]), 32'hF0F0);

    for (int i = 0; i < NW; i++) img[i] = 16'($urandom_range(0, 65535));
    for (int i = 0; i < 6; i += 3) begin
      img[i] = 16'hFF00;
      img[i+1] = 16'h0000;
      img[i+2] = 16'h00FF;
    end
    run_frame(4);
    chk("rb_y0", 32'(wr[0]), 32'h5229);
    chk("rb_u0", 32'(wr[int'(DEF_U_BASE)]), 32'hA5A5);
    chk("rb_v0", 32'(wr[int'(DEF_V_BASE)]), 32'hAFAF);

    wr.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2000 && t != 12 * 100 + 10; i++) tick();
    chk("reach_g9", 32'(t), 32'(12 * 100 + 10));
    resetn = 1'b0;
    tick();
    chk("mid_rst_addr", 32'(addr), 32'(DEF_RGB_BASE));
    chk("mid_rst_wdata", 32'(wdata), 32'd0);
    chk("mid_rst_we_n", 32'(we_n), 32'd1);
    chk("mid_rst_done", 32'(done), 32'd0);
    resetn = 1'b1;
    tick();
    wr.delete();
    run_frame(0);
    chk("restart_y0", 32'(wr[0]), 32'h5229);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
